// File: rtl/mac_pipeline_if.sv
// Operand/result bundle for the double-precision MAC multiply front end.
// The producer drives operands, and mac_pipeline drives the formatted product.
interface mac_pipeline_if #(
  parameter int PROD_W = 90
);
  logic [63:0]       TA_in;
  logic [63:0]       TB_in;
  logic [PROD_W-1:0] MAB_mul_res_signed;
  logic [11:0]       MAB_exp_res;
  logic              error_flag;

  modport master (
    output TA_in,
    output TB_in,
    input  MAB_mul_res_signed,
    input  MAB_exp_res,
    input  error_flag
  );

  modport slave (
    input  TA_in,
    input  TB_in,
    output MAB_mul_res_signed,
    output MAB_exp_res,
    output error_flag
  );
endinterface

// File: rtl/mac_pipeline.sv
// binary64 x binary64 multiply front end: unpack, multiply, format.
// Emits a truncated signed significand and a biased exponent, with 3-cycle latency.
module mac_pipeline #(
  parameter int LATENCY = 3,
  parameter int PROD_W  = 90,
  parameter int TRUNC   = 17
) (
  input  logic           clk,
  input  logic           rst,
  mac_pipeline_if.slave  bus
);

  localparam int MAG_W = PROD_W - 1;

  if (LATENCY != 3 || MAG_W != 106 - TRUNC) begin : g_bad_params
    $error("mac_pipeline: unsupported parameter set");
  end

  typedef struct packed {
    logic        sign;
    logic [52:0] ma;
    logic [52:0] mb;
    logic [11:0] esum;
    logic        zero;
    logic        err;
  } s1_t;

  typedef struct packed {
    logic             sign;
    logic [MAG_W-1:0] mag;
    logic [11:0]      esum;
    logic             zero;
    logic             err;
  } s2_t;

  s1_t s1;
  s2_t s2;

  logic [10:0] ea, eb;
  logic [51:0] fa, fb;
  logic        a_zero, b_zero;
  logic        a_den, b_den;
  logic        a_spc, b_spc;
  logic        any_zero;
  logic        range_bad;
  logic        err_c;
  logic signed [12:0] esum_c;

  assign ea = bus.TA_in[62:52];
  assign eb = bus.TB_in[62:52];
  assign fa = bus.TA_in[51:0];
  assign fb = bus.TB_in[51:0];

  assign a_zero = (ea == 11'd0) && (fa == 52'd0);
  assign b_zero = (eb == 11'd0) && (fb == 52'd0);
  assign a_den  = (ea == 11'd0) && (fa != 52'd0);
  assign b_den  = (eb == 11'd0) && (fb != 52'd0);
  assign a_spc  = &ea;
  assign b_spc  = &eb;

  assign esum_c = $signed({2'b00, ea})
                + $signed({2'b00, eb})
                - 13'sd1023;

  assign range_bad = (esum_c < 13'sd1)
                  || (esum_c > 13'sd2046);

  assign any_zero = a_zero | b_zero;

  // Inf/NaN/denormal poison the result even if the other operand is zero.
  assign err_c = a_spc | b_spc | a_den | b_den
               | (!any_zero && range_bad);

  // Stage 1: unpack and classify.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1 <= '0;
    end else begin
      s1.sign <= bus.TA_in[63] ^ bus.TB_in[63];
      s1.ma   <= {(ea != 11'd0), fa};
      s1.mb   <= {(eb != 11'd0), fb};
      s1.esum <= esum_c[11:0];
      s1.zero <= any_zero;
      s1.err  <= err_c;
    end
  end

  logic [105:0]     p_full;
  logic [MAG_W-1:0] p_mag;
  logic [TRUNC-1:0] p_unused_lo;

  assign p_full = 106'(s1.ma) * 106'(s1.mb);
  assign {p_mag, p_unused_lo} = p_full;

  // Stage 2: multiply; only the bits that survive truncation are kept.
  always_ff @(posedge clk) begin
    if (rst) begin
      s2 <= '0;
    end else begin
      s2.sign <= s1.sign;
      s2.mag  <= p_mag;
      s2.esum <= s1.esum;
      s2.zero <= s1.zero;
      s2.err  <= s1.err;
    end
  end

  logic              kill;
  logic [PROD_W-1:0] mag_ext;

  assign kill    = s2.err | s2.zero;
  assign mag_ext = {1'b0, s2.mag};

  // Stage 3: sign-apply without normalising; the accumulator absorbs [2,4).
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.MAB_mul_res_signed <= '0;
      bus.MAB_exp_res        <= '0;
      bus.error_flag         <= 1'b0;
    end else begin
      bus.error_flag <= s2.err;
      if (kill) begin
        bus.MAB_mul_res_signed <= '0;
        bus.MAB_exp_res        <= '0;
      end else begin
        bus.MAB_mul_res_signed <= s2.sign ? -mag_ext : mag_ext;
        bus.MAB_exp_res        <= s2.esum;
      end
    end
  end

endmodule

// File: tb/tb_mac_pipeline.sv
// Directed self-checking bench for mac_pipeline.
// Expected values are derived from operand fields by hand.
module tb_mac_pipeline;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  mac_pipeline_if #(.PROD_W(90)) bus ();

  mac_pipeline dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  localparam logic [63:0] D_ONE  = 64'h3FF0000000000000;
  localparam logic [63:0] D_TWO  = 64'h4000000000000000;
  localparam logic [63:0] D_THR  = 64'h4008000000000000;
  localparam logic [63:0] D_HALF = 64'h3FE0000000000000;
  localparam logic [63:0] D_M4   = 64'hC010000000000000;
  localparam logic [63:0] D_M165 = 64'hBFFA000000000000;
  localparam logic [63:0] D_2P6  = 64'h4004CCCCCCCCCCCD;
  localparam logic [63:0] D_INF  = 64'h7FF0000000000000;
  localparam logic [63:0] D_NAN  = 64'h7FF8000000000000;
  localparam logic [63:0] D_DEN  = 64'h0000000000000001;
  localparam logic [63:0] D_NZ   = 64'h8000000000000000;
  localparam logic [63:0] D_BIG  = 64'h7FE0000000000000;
  localparam logic [63:0] D_MIN  = 64'h0010000000000000;
  localparam logic [63:0] D_HMIN = 64'h3FE0000000000000;

  localparam logic [89:0] P_ONE  = 90'd1 << 87;
  localparam logic [89:0] P_1P5  = 90'd3 << 86;
  localparam logic [89:0] P_NEG1 = ~P_ONE + 90'd1;

  int n_assert = 0;
  int n_fail   = 0;

  logic [105:0] pw;
  logic [89:0]  p_sign;

  task automatic chk(input string tag,
                     input logic [89:0] p,
                     input logic [11:0] e,
                     input logic f);
    n_assert++;
    assert (bus.MAB_mul_res_signed === p) else begin
      n_fail++;
      $error("FAIL %s prod got %h want %h",
             tag, bus.MAB_mul_res_signed, p);
    end
    n_assert++;
    assert (bus.MAB_exp_res === e) else begin
      n_fail++;
      $error("FAIL %s exp got %0d want %0d",
             tag, bus.MAB_exp_res, e);
    end
    n_assert++;
    assert (bus.error_flag === f) else begin
      n_fail++;
      $error("FAIL %s flag got %b want %b",
             tag, bus.error_flag, f);
    end
  endtask

  task automatic drive(input logic [63:0] a,
                       input logic [63:0] b);
    @(negedge clk);
    bus.TA_in = a;
    bus.TB_in = b;
  endtask

  task automatic run1(input string tag,
                      input logic [63:0] a,
                      input logic [63:0] b,
                      input logic [89:0] p,
                      input logic [11:0] e,
                      input logic f);
    drive(a, b);
    repeat (3) @(posedge clk);
    #1;
    chk(tag, p, e, f);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    bus.TA_in = D_ONE;
    bus.TB_in = D_ONE;

    // reset held across two edges with valid operands present
    repeat (2) begin
      @(posedge clk);
      #1;
      chk("reset", '0, '0, 1'b0);
    end
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("post_rst0", '0, '0, 1'b0);
    @(posedge clk); #1;
    chk("post_rst1", '0, '0, 1'b0);
    @(posedge clk); #1;
    chk("first", P_ONE, 12'd1023, 1'b0);

    run1("one_x_one", D_ONE, D_ONE, P_ONE, 12'd1023, 1'b0);
    run1("two_x_three", D_TWO, D_THR, P_1P5, 12'd1025, 1'b0);
    run1("half_x_m4", D_HALF, D_M4, P_NEG1, 12'd1024, 1'b0);

    pw = 106'h1A000000000000 * 106'h14CCCCCCCCCCCD;
    p_sign = ~{1'b0, pw[105:17]} + 90'd1;
    run1("sign_case", D_M165, D_2P6, p_sign, 12'd1024, 1'b0);

    run1("zero_a", 64'd0, D_ONE, '0, '0, 1'b0);
    run1("negzero_b", D_TWO, D_NZ, '0, '0, 1'b0);
    run1("zero_x_big", 64'd0, D_BIG, '0, '0, 1'b0);
    run1("inf_a", D_INF, D_ONE, '0, '0, 1'b1);
    run1("nan_b", D_ONE, D_NAN, '0, '0, 1'b1);
    run1("inf_x_zero", D_INF, 64'd0, '0, '0, 1'b1);
    run1("denorm_a", D_DEN, D_ONE, '0, '0, 1'b1);
    run1("ovf", D_BIG, D_BIG, '0, '0, 1'b1);
    run1("unf", D_MIN, D_MIN, '0, '0, 1'b1);
    run1("esum_2046", D_BIG, D_ONE, P_ONE, 12'd2046, 1'b0);
    run1("esum_2047", D_BIG, D_TWO, '0, '0, 1'b1);
    run1("esum_1", D_MIN, D_ONE, P_ONE, 12'd1, 1'b0);
    run1("esum_0", D_MIN, D_HMIN, '0, '0, 1'b1);

    // back-to-back operands, one result per cycle
    drive(D_ONE, D_ONE);
    drive(D_TWO, D_THR);
    drive(D_HALF, D_M4);
    drive(D_INF, D_ONE);
    chk("tp0", P_ONE, 12'd1023, 1'b0);
    @(negedge clk);
    chk("tp1", P_1P5, 12'd1025, 1'b0);
    @(negedge clk);
    chk("tp2", P_NEG1, 12'd1024, 1'b0);
    @(negedge clk);
    chk("tp3", '0, '0, 1'b1);

    // reset mid-stream drops everything in flight
    drive(D_TWO, D_THR);
    drive(D_HALF, D_M4);
    drive(D_ONE, D_ONE);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mid_rst0", '0, '0, 1'b0);
    @(negedge clk);
    chk("mid_rst1", '0, '0, 1'b0);
    @(negedge clk);
    chk("mid_rst2", '0, '0, 1'b0);
    @(negedge clk);
    chk("mid_rst_new", P_ONE, 12'd1023, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
